// File: rtl/ac_motor_ramp_sequencer.sv
// Soft-start/soft-stop power ramp sequencer for the AC motor control block.
// Owns the CW/CCW enables, sequences reversals through a dead time and provides an E-stop override.
module ac_motor_ramp_sequencer #(
  parameter int unsigned resolution_bits = 12,
  parameter int unsigned STEP_DIV        = 1000,
  parameter int unsigned STEP_SIZE       = 1,
  parameter int unsigned DEAD_TICKS      = 8
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       ENABLE,
  input  logic                       DIR_REQ,
  input  logic [resolution_bits-1:0] TARGET,
  input  logic                       ESTOP,
  output logic [resolution_bits-1:0] POWER,
  output logic                       CW,
  output logic                       CCW,
  output logic [2:0]                 STATE,
  output logic                       BUSY
);

  localparam int unsigned RW = resolution_bits;
  localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAMP     = 3'd1,
    S_RUN      = 3'd2,
    S_STOPPING = 3'd3,
    S_REVERSE  = 3'd4,
    S_DEAD     = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [RW-1:0] power_q, power_d;
  logic          cw_q, cw_d, ccw_q, ccw_d;
  logic          dir_q, dir_d;
  logic          busy_q, busy_d;
  logic          tick;
  logic          step_en;
  logic [RW-1:0] goal;

  // Move one step toward goal; land exactly on goal when within one step.
  function automatic logic [RW-1:0] step_toward(input logic [RW-1:0] cur, input logic [RW-1:0] tgt);
    logic [RW-1:0] res;
    if (tgt > cur) begin
      if (32'(tgt - cur) <= STEP_SIZE) res = tgt;
      else                             res = cur + RW'(STEP_SIZE);
    end else begin
      if (32'(cur - tgt) <= STEP_SIZE) res = tgt;
      else                             res = cur - RW'(STEP_SIZE);
    end
    return res;
  endfunction

  assign tick = (presc_q == PW'(STEP_DIV - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      dead_q  <= '0;
      power_q <= '0;
      cw_q    <= 1'b0;
      ccw_q   <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dead_q  <= dead_d;
      power_q <= power_d;
      cw_q    <= cw_d;
      ccw_q   <= ccw_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    power_d = power_q;
    cw_d    = cw_q;
    ccw_d   = ccw_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    goal    = TARGET;
    step_en = 1'b0;

    if (ESTOP && state_q != S_FAULT) begin
      state_d = S_FAULT;
      power_d = '0;
      cw_d    = 1'b0;
      ccw_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          power_d = '0;
          cw_d    = 1'b0;
          ccw_d   = 1'b0;
          if (ENABLE && TARGET != '0) begin
            state_d = S_RAMP;
            dir_d   = DIR_REQ;
            cw_d    = ~DIR_REQ;
            ccw_d   = DIR_REQ;
          end
        end
        S_RAMP: begin
          if (!ENABLE)                  state_d = S_STOPPING;
          else if (DIR_REQ != dir_q)    state_d = S_REVERSE;
          else if (power_q == TARGET) begin
            if (TARGET != '0) state_d = S_RUN;
            else begin
              state_d = S_IDLE;
              cw_d    = 1'b0;
              ccw_d   = 1'b0;
            end
          end else                      step_en = 1'b1;
        end
        S_RUN: begin
          if (!ENABLE)                  state_d = S_STOPPING;
          else if (DIR_REQ != dir_q)    state_d = S_REVERSE;
          else if (TARGET != power_q)   state_d = S_RAMP;
        end
        S_STOPPING: begin
          goal = '0;
          if (ENABLE && DIR_REQ == dir_q) state_d = S_RAMP;
          else if (ENABLE)                state_d = S_REVERSE;
          else if (power_q == '0) begin
            state_d = S_IDLE;
            cw_d    = 1'b0;
            ccw_d   = 1'b0;
          end else                        step_en = 1'b1;
        end
        S_REVERSE: begin
          // Old direction stays asserted until power reaches zero.
          goal = '0;
          if (!ENABLE)              state_d = S_STOPPING;
          else if (power_q == '0) begin
            state_d = S_DEAD;
            cw_d    = 1'b0;
            ccw_d   = 1'b0;
            dead_d  = '0;
          end else                  step_en = 1'b1;
        end
        S_DEAD: begin
          if (!ENABLE) state_d = S_IDLE;
          else if (tick) begin
            if (dead_q == DW'(DEAD_TICKS - 1)) begin
              state_d = S_RAMP;
              dir_d   = DIR_REQ;
              cw_d    = ~DIR_REQ;
              ccw_d   = DIR_REQ;
            end else begin
              dead_d = dead_q + DW'(1);
            end
          end
        end
        S_FAULT: begin
          power_d = '0;
          cw_d    = 1'b0;
          ccw_d   = 1'b0;
          if (!ESTOP && !ENABLE) state_d = S_IDLE;
        end
        default: begin
          state_d = S_FAULT;
          power_d = '0;
          cw_d    = 1'b0;
          ccw_d   = 1'b0;
        end
      endcase
    end

    // A state transition on a tick edge suppresses the step.
    if (step_en && tick && state_d == state_q) power_d = step_toward(power_q, goal);

    if (state_d != state_q) presc_d = '0;
    else if (tick)          presc_d = '0;
    else                    presc_d = presc_q + PW'(1);

    busy_d = (state_d == S_RAMP) || (state_d == S_STOPPING) ||
             (state_d == S_REVERSE) || (state_d == S_DEAD);
  end

  assign POWER = power_q;
  assign CW    = cw_q;
  assign CCW   = ccw_q;
  assign STATE = state_q;
  assign BUSY  = busy_q;

endmodule
